vend_fsm: RTL and testbench

Purchase controller for the vending machine.
- Accumulates coin pulses into a credit total and decides purchase, cancel or timeout.
- Drives the dispense and refund outputs and the change value.
- Emits a one-cycle buy_ok pulse that feeds the downstream buzzer driver's start-beep input.
- Sits between the debounced key/coin pulse generators and the buzzer, display and actuator logic.

---
 rtl/vend_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_vend_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_fsm.sv
`default_nettype none
// ============================================================================
// Module   : vend_fsm
// Purpose  : Purchase controller for the vending machine. Accumulates coin
//            pulses into a credit total, then resolves purchase, cancel or
//            inactivity timeout. Drives dispense/refund levels, the change
//            amount, a one-cycle buy_ok pulse (buzzer start-beep) and a
//            ready status (buzzer status input).
// Ports    : clk        - system clock (50 MHz)
//            rst_n      - asynchronous active-low reset
//            coin_half  - 1-cycle pulse, 0.5 yuan inserted
//            coin_one   - 1-cycle pulse, 1 yuan inserted
//            cancel     - 1-cycle pulse, user cancel request
//            credit     - accumulated credit, half-yuan units
//            change     - change/refund amount, valid with dispense/refund
//            dispense   - high for the whole DISPENSE state
//            refund     - high for the whole REFUND state
//            buy_ok     - 1-cycle pulse on purchase
//            ready      - high in IDLE only
// Revision : 1.0 - initial release
// ============================================================================
module vend_fsm #(
  parameter int unsigned PRICE       = 5,
  parameter logic [27:0] TIMEOUT_CYC = 28'd250_000_000,
  parameter logic [24:0] HOLD_CYC    = 25'd25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_half,
  input  logic       coin_one,
  input  logic       cancel,
  output logic [4:0] credit,
  output logic [4:0] change,
  output logic       dispense,
  output logic       refund,
  output logic       buy_ok,
  output logic       ready
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_COLLECT  = 2'd1;
  localparam logic [1:0] c_DISPENSE = 2'd2;
  localparam logic [1:0] c_REFUND   = 2'd3;

  localparam logic [5:0]  c_PRICE    = 6'(PRICE);
  localparam logic [27:0] c_TMO_LAST = TIMEOUT_CYC - 28'd1;
  localparam logic [24:0] c_HLD_LAST = HOLD_CYC - 25'd1;

  // State and registered outputs
  logic [1:0]  r_state;
  logic [27:0] r_tcnt;
  logic [24:0] r_hcnt;
  logic [4:0]  r_credit;
  logic [4:0]  r_change;
  logic        r_dispense;
  logic        r_refund;
  logic        r_buy_ok;
  logic        r_ready;

  // Next-state values
  logic [1:0]  w_state_nxt;
  logic [27:0] w_tcnt_nxt;
  logic [24:0] w_hcnt_nxt;
  logic [4:0]  w_credit_nxt;
  logic [4:0]  w_change_nxt;
  logic        w_dispense_nxt;
  logic        w_refund_nxt;
  logic        w_buy_ok_nxt;
  logic        w_ready_nxt;

  // Coin arithmetic and event decode
  logic [5:0] w_add;
  logic [5:0] w_sum;
  logic       w_in_idle;
  logic       w_in_collect;
  logic       w_in_hold;
  logic       w_coin;
  logic       w_cancel_ev;
  logic       w_buy_ev;
  logic       w_coin_ev;
  logic       w_tmo_ev;
  logic       w_hold_done;

  // Both coin pulses in one cycle add up to 3 half-yuan units.
  assign w_add = {5'd0, coin_half} + {4'd0, coin_one, 1'b0};
  assign w_sum = {1'b0, r_credit} + w_add;

  assign w_in_idle    = (r_state == c_IDLE);
  assign w_in_collect = (r_state == c_COLLECT);
  assign w_in_hold    = (r_state == c_DISPENSE) || (r_state == c_REFUND);
  assign w_coin       = (w_add != 6'd0);

  // COLLECT priority: cancel > purchase > coin > timeout.
  assign w_cancel_ev = w_in_collect && cancel;
  assign w_buy_ev    = (w_in_idle && (w_add >= c_PRICE)) ||
                       (w_in_collect && !cancel && (w_sum >= c_PRICE));
  assign w_coin_ev   = w_coin && !w_buy_ev && (w_in_idle || (w_in_collect && !cancel));
  assign w_tmo_ev    = w_in_collect && !cancel && !w_coin && (r_tcnt == c_TMO_LAST);
  assign w_hold_done = w_in_hold && (r_hcnt == c_HLD_LAST);

  // --------------------------------------------------------------------------
  // State register (also holds counters and the registered outputs)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_tcnt     <= 28'd0;
      r_hcnt     <= 25'd0;
      r_credit   <= 5'd0;
      r_change   <= 5'd0;
      r_dispense <= 1'b0;
      r_refund   <= 1'b0;
      r_buy_ok   <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_credit   <= w_credit_nxt;
      r_change   <= w_change_nxt;
      r_dispense <= w_dispense_nxt;
      r_refund   <= w_refund_nxt;
      r_buy_ok   <= w_buy_ok_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_hcnt_nxt  = r_hcnt;
    case (r_state)
      c_IDLE: begin
        if (w_buy_ev) begin
          w_state_nxt = c_DISPENSE;
          w_hcnt_nxt  = 25'd0;
        end else if (w_coin_ev) begin
          w_state_nxt = c_COLLECT;
          w_tcnt_nxt  = 28'd0;
        end
      end
      c_COLLECT: begin
        if (w_cancel_ev || w_tmo_ev) begin
          w_state_nxt = c_REFUND;
          w_hcnt_nxt  = 25'd0;
        end else if (w_buy_ev) begin
          w_state_nxt = c_DISPENSE;
          w_hcnt_nxt  = 25'd0;
        end else if (w_coin_ev) begin
          w_tcnt_nxt  = 28'd0;
        end else begin
          w_tcnt_nxt  = r_tcnt + 28'd1;
        end
      end
      default: begin
        // DISPENSE / REFUND: coins and cancel are ignored while holding.
        if (w_hold_done) begin
          w_state_nxt = c_IDLE;
          w_hcnt_nxt  = 25'd0;
        end else begin
          w_hcnt_nxt  = r_hcnt + 25'd1;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (values registered on the next edge)
  // --------------------------------------------------------------------------
  always_comb begin
    w_credit_nxt = r_credit;
    w_change_nxt = r_change;
    w_buy_ok_nxt = w_buy_ev;
    if (w_cancel_ev) begin
      // A coin landing together with cancel is returned as well.
      w_change_nxt = w_sum[4:0];
      w_credit_nxt = 5'd0;
    end else if (w_buy_ev) begin
      w_change_nxt = 5'(w_sum - c_PRICE);
      w_credit_nxt = 5'd0;
    end else if (w_coin_ev) begin
      w_credit_nxt = w_sum[4:0];
    end else if (w_tmo_ev) begin
      w_change_nxt = r_credit;
      w_credit_nxt = 5'd0;
    end else if (w_hold_done) begin
      w_change_nxt = 5'd0;
    end
    w_dispense_nxt = (w_state_nxt == c_DISPENSE);
    w_refund_nxt   = (w_state_nxt == c_REFUND);
    w_ready_nxt    = (w_state_nxt == c_IDLE);
  end

  assign credit   = r_credit;
  assign change   = r_change;
  assign dispense = r_dispense;
  assign refund   = r_refund;
  assign buy_ok   = r_buy_ok;
  assign ready    = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_vend_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_fsm
// Purpose  : Directed self-checking bench for vend_fsm with PRICE=5,
//            TIMEOUT_CYC=100, HOLD_CYC=10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_fsm;

  logic       clk;
  logic       rst_n;
  logic       coin_half;
  logic       coin_one;
  logic       cancel;
  logic [4:0] credit;
  logic [4:0] change;
  logic       dispense;
  logic       refund;
  logic       buy_ok;
  logic       ready;

  int n_cmp;
  int n_err;
  int cnt_a;
  int cnt_b;
  int cnt_c;

  vend_fsm #(
    .PRICE      (5),
    .TIMEOUT_CYC(28'd100),
    .HOLD_CYC   (25'd10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .coin_half(coin_half),
    .coin_one (coin_one),
    .cancel   (cancel),
    .credit   (credit),
    .change   (change),
    .dispense (dispense),
    .refund   (refund),
    .buy_ok   (buy_ok),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic cyc(input logic h, input logic o, input logic c);
    coin_half = h;
    coin_one  = o;
    cancel    = c;
    @(posedge clk);
    #1;
    coin_half = 1'b0;
    coin_one  = 1'b0;
    cancel    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    coin_half = 1'b0;
    coin_one  = 1'b0;
    cancel    = 1'b0;

    // Reset state
    #12;
    chk("rst_credit", credit, 0);
    chk("rst_change", change, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_refund", refund, 0);
    chk("rst_buy_ok", buy_ok, 0);
    chk("rst_ready", ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b1);  // cancel in IDLE is ignored
    chk("idle_cancel_ready", ready, 1);
    chk("idle_cancel_refund", refund, 0);

    // 1. Exact payment
    cyc(1'b0, 1'b1, 1'b0);
    chk("t1_credit2", credit, 2);
    chk("t1_ready_low", ready, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t1_credit4", credit, 4);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t1_buy_ok", buy_ok, 1);
    chk("t1_dispense", dispense, 1);
    chk("t1_change", change, 0);
    chk("t1_credit0", credit, 0);
    cnt_a = 1;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (dispense) cnt_a++;
      if (buy_ok) cnt_b++;
    end
    chk("t1_dispense_cycles", cnt_a, 10);
    chk("t1_buy_ok_single", cnt_b, 0);
    chk("t1_ready_back", ready, 1);

    // 2. Overpay
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t2_dispense", dispense, 1);
    chk("t2_change", change, 1);
    chk("t2_credit", credit, 0);
    idle(9);
    chk("t2_dispense_last", dispense, 1);
    chk("t2_change_last", change, 1);
    chk("t2_ready_hold", ready, 0);
    idle(1);
    chk("t2_dispense_end", dispense, 0);
    chk("t2_change_end", change, 0);
    chk("t2_ready_end", ready, 1);

    // 3. Cancel with simultaneous coin
    cyc(1'b0, 1'b1, 1'b0);
    chk("t3_credit2", credit, 2);
    cyc(1'b1, 1'b0, 1'b1);
    chk("t3_refund", refund, 1);
    chk("t3_change", change, 3);
    chk("t3_buy_ok", buy_ok, 0);
    chk("t3_dispense", dispense, 0);
    chk("t3_credit0", credit, 0);
    idle(10);
    chk("t3_refund_end", refund, 0);
    chk("t3_change_end", change, 0);
    chk("t3_ready_end", ready, 1);

    // 4a. Plain timeout
    cyc(1'b1, 1'b0, 1'b0);
    chk("t4_credit1", credit, 1);
    idle(99);
    chk("t4_no_refund_99", refund, 0);
    chk("t4_credit_99", credit, 1);
    idle(1);
    chk("t4_refund_100", refund, 1);
    chk("t4_change", change, 1);
    chk("t4_credit0", credit, 0);
    idle(10);
    chk("t4_ready_end", ready, 1);

    // 4b. Coin at cycle 60 restarts the timeout
    cyc(1'b1, 1'b0, 1'b0);
    idle(59);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t4b_credit2", credit, 2);
    idle(99);
    chk("t4b_no_refund_99", refund, 0);
    chk("t4b_credit_99", credit, 2);
    idle(1);
    chk("t4b_refund_100", refund, 1);
    chk("t4b_change", change, 2);
    idle(10);
    chk("t4b_refund_end", refund, 0);

    // 5. Simultaneous coins, then rejection during hold
    cyc(1'b1, 1'b1, 1'b0);
    chk("t5_credit3", credit, 3);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t5_dispense", dispense, 1);
    chk("t5_change", change, 0);
    chk("t5_buy_ok", buy_ok, 1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t5_hold_credit_a", credit, 0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t5_hold_credit_b", credit, 0);
    chk("t5_hold_refund", refund, 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t5_hold_change", change, 0);
    idle(7);
    chk("t5_dispense_end", dispense, 0);
    chk("t5_credit_end", credit, 0);
    chk("t5_ready_end", ready, 1);

    // 6. Reset mid-COLLECT
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t6_credit4", credit, 4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_credit", credit, 0);
    chk("t6_rst_ready", ready, 1);
    chk("t6_rst_change", change, 0);
    #2;
    rst_n = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (refund) cnt_a++;
      if (buy_ok) cnt_b++;
      if (!ready || credit != 5'd0) cnt_c++;
    end
    chk("t6_no_refund", cnt_a, 0);
    chk("t6_no_buy_ok", cnt_b, 0);
    chk("t6_stays_idle", cnt_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
